fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline.
- Owns the PC register and computes PC+4 with a 32-bit adder.
- Issues requests to instruction memory and handles memory wait states, hazard-unit stalls, branch/jump redirects from EX and decode flushes.
- Drives the IF/ID pipeline register that feeds the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID on reset and on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_f  in  1  hazard unit: hold PC and IF/ID.
- flush_d  in  1  hazard unit: replace IF/ID contents with a bubble.
- pc_src_e  in  1  EX-stage redirect (taken branch/jump).
- pc_target_e  in  32  redirect target from EX.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, equal to pc_f.
- imem_ready  in  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  in  32  fetched instruction word.
- pc_f  out  32  current fetch PC.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc_plus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst=0):
  - pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
  - Skid buffer cleared, state=BOOT, imem_req=0.
- Arithmetic: pc+4 is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal. pc_target_e[1:0] is ignored (forced to 0), so pc_f[1:0] is always 0.
- imem_addr=pc_f and is combinational. imem_req=1 only in state REQ.
- States:
  - BOOT:
    - imem_req=0.
    - Next cycle goes to REQ. The first request issues in the first cycle after reset is released.
  - REQ, imem_ready=1, stall_f=0:
    - IF/ID <= {imem_rdata, pc_f, pc_f+4, valid=1}.
    - pc_f <= pc_f+4. Stay in REQ. Throughput is 1 instruction per cycle.
  - REQ, imem_ready=1, stall_f=1:
    - Skid <= imem_rdata; IF/ID and pc_f hold; go to HOLD.
  - REQ, imem_ready=0, stall_f=0:
    - IF/ID <= bubble (NOP_INSTR, valid=0; pc_d and pc_plus4_d hold). pc_f holds.
  - REQ, imem_ready=0, stall_f=1:
    - Everything holds.
  - HOLD:
    - imem_req=0.
    - If stall_f=0: IF/ID <= {skid, pc_f, pc_f+4, 1}, pc_f <= pc_f+4, go to REQ. Otherwise hold.
- Redirect (pc_src_e=1):
  - Highest priority, in any state including BOOT, and overrides stall_f.
  - pc_f <= pc_target_e. IF/ID <= bubble. Skid is discarded. State <= REQ (from BOOT as well).
  - Any imem_ready in the same cycle is ignored (wrong path).
- flush_d=1 without pc_src_e:
  - IF/ID <= bubble.
  - A response arriving that cycle is dropped and pc_f does NOT advance, so the same PC is re-fetched.
  - In HOLD, the skid is discarded and the state goes to REQ.
  - flush_d overrides stall_f for IF/ID; pc_f holds.
- Priority: rst > pc_src_e > flush_d > stall_f > normal flow.
- Latency: an instruction accepted at edge N appears on instr_d after edge N; a redirect costs 2 bubbles minimum (the F slot and the D slot).
- Reset asserted mid-wait or in HOLD: immediate return to reset values. A pending response arriving after reset release is not captured (state is BOOT, no request outstanding).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on every IF/ID load with valid=1.
  - stall_count increments each cycle in HOLD, or in REQ with imem_ready=0 and pc_src_e=0.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready tied 1 with memory returning 32'h00A00093 at address 0 -> BOOT cycle has imem_req=0; addresses 0,4,8 then issue on consecutive cycles; after the first accepting edge instr_d=32'h00A00093, pc_d=0, pc_plus4_d=4, valid_d=1.
- imem_ready=0 for 3 cycles at pc_f=8 -> pc_f stays 8, 3 bubbles (valid_d=0, instr_d=32'h00000013); the word at 8 is loaded when ready rises.
- stall_f=1 in a cycle where imem_ready=1 at pc_f=12 -> HOLD entered, imem_req=0, IF/ID unchanged; when stall_f drops, instr_d=skid word, pc_d=12, pc_f=16.
- pc_src_e=1 with pc_target_e=32'h0000_0103 while stall_f=1 and imem_ready=1 -> pc_f=32'h0000_0100, valid_d=0, the response is dropped, and the next fetch goes to 0x100.
- flush_d=1 alone at pc_f=20 with imem_ready=1 -> valid_d=0, pc_f stays 20, and the word at 20 is re-fetched the next cycle.
- pc_f=32'hFFFF_FFFC fetched -> pc_plus4_d=0 and the next pc_f=0. With FETCH_PERF_CNT_EN defined, fetch_count matches the number of valid loads and stall_count matches the number of wait/HOLD cycles.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32 fetch stage: PC register, imem request/wait handling, one-entry skid for stalled responses, IF/ID register.
// One instruction per cycle; result visible after the accepting edge. FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_f_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    skid_d     = skid_q;
    if (pc_src_e) begin
      // Whatever memory returns this cycle belongs to the wrong path.
      pc_f_d     = pc_target_e & ~32'd3;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      skid_d     = '0;
      state_d    = ST_REQ;
    end else if (flush_d) begin
      // PC holds so the dropped word is fetched again.
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      skid_d     = '0;
      state_d    = ST_REQ;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ready && !stall_f) begin
            id_instr_d = imem_rdata;
            id_pc_d    = pc_f_q;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
            pc_f_d     = pc_plus4;
          end else if (imem_ready) begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end else if (!stall_f) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall_f) begin
            id_instr_d = skid_q;
            id_pc_d    = pc_f_q;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
            pc_f_d     = pc_plus4;
            state_d    = ST_REQ;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_f_q     <= RESET_PC & ~32'd3;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      skid_q     <= skid_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = pc_f_q;
  assign pc_f       = pc_f_q;
  assign instr_d    = id_instr_q;
  assign pc_d       = id_pc_q;
  assign pc_plus4_d = id_pc4_q;
  assign valid_d    = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        fetch_evt, stall_evt;

  assign fetch_evt = !pc_src_e && !flush_d && !stall_f &&
                     (((state_q == ST_REQ) && imem_ready) || (state_q == ST_HOLD));
  assign stall_evt = (state_q == ST_HOLD) || ((state_q == ST_REQ) && !imem_ready && !pc_src_e);

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_evt};
    stall_cnt_d = stall_cnt_q + {31'd0, stall_evt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a queue-based fetch model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_f, flush_d, pc_src_e, imem_ready, imem_req, valid_d;
  logic [31:0] pc_target_e, imem_rdata, imem_addr, pc_f, instr_d, pc_d, pc_plus4_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: architectural fetch state, with a held word queued while decode is stalled.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_fetch, m_stall;
  logic        m_valid, m_boot;
  logic [31:0] m_held[$];

  logic [129:0] dut_vec;
  assign dut_vec = {imem_req, pc_f, instr_d, pc_d, pc_plus4_d, valid_d};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [129:0] exp_vec();
    logic req;
    req = !m_boot && (m_held.size() == 0);
    return {req, m_pc, m_instr, m_pcd, m_pc4, m_valid};
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    m_boot = 1'b1; m_held.delete(); m_fetch = 32'd0; m_stall = 32'd0;
  endtask

  task automatic model_accept(input logic [31:0] w);
    m_instr = w; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    m_pc = m_pc + 32'd4; m_fetch = m_fetch + 32'd1;
  endtask

  task automatic model_bubble();
    m_instr = NOP; m_valid = 1'b0;
  endtask

  // Drives one cycle of stimulus, advances the model, returns 1 time unit after the edge.
  task automatic step(input bit st, input bit fl, input bit src, input logic [31:0] tgt, input bit rdy);
    stall_f = st; flush_d = fl; pc_src_e = src; pc_target_e = tgt; imem_ready = rdy;
    imem_rdata = rdy ? mem_word(imem_addr) : $urandom;
    if (m_held.size() != 0 || (!m_boot && !rdy && !src)) m_stall = m_stall + 32'd1;
    if (src) begin
      m_pc = tgt & ~32'd3; model_bubble(); m_held.delete(); m_boot = 1'b0;
    end else if (fl) begin
      model_bubble(); m_held.delete(); m_boot = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_held.size() != 0) begin
      if (!st) model_accept(m_held.pop_front());
    end else if (rdy && !st) begin
      model_accept(mem_word(m_pc));
    end else if (rdy) begin
      m_held.push_back(mem_word(m_pc));
    end else if (!st) begin
      model_bubble();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_f = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc_f !== 32'd0) begin failures++; $display("FAIL reset_pc_f got=%h exp=%h", pc_f, 32'd0); end
    checks++; if (instr_d !== NOP) begin failures++; $display("FAIL reset_instr_d got=%h exp=%h", instr_d, NOP); end
    checks++; if (pc_d !== 32'd0 || pc_plus4_d !== 32'd0) begin failures++; $display("FAIL reset_pcs got=%h/%h exp=0/0", pc_d, pc_plus4_d); end
    checks++; if (valid_d !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL reset_valid_req got=%b/%b exp=0/0", valid_d, imem_req); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", imem_req); end
  endtask

  task automatic test_boot_stream();
    step(0, 0, 0, 32'd0, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    step(0, 0, 0, 32'd0, 1);
    checks++; if (instr_d !== 32'h00A0_0093 || pc_d !== 32'd0 || pc_plus4_d !== 32'd4 || valid_d !== 1'b1)
      begin failures++; $display("FAIL first_load got=%h/%h/%h/%b exp=00a00093/0/4/1", instr_d, pc_d, pc_plus4_d, valid_d); end
    checks++; if (imem_addr !== 32'd4) begin failures++; $display("FAIL second_addr got=%h exp=4", imem_addr); end
    step(0, 0, 0, 32'd0, 1);
    checks++; if (imem_addr !== 32'd8 || dut_vec !== exp_vec()) begin failures++; $display("FAIL third_addr got=%h vec=%h exp=8 vec=%h", imem_addr, dut_vec, exp_vec()); end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'd0, 0);
      checks++; if (pc_f !== 32'd8 || valid_d !== 1'b0 || instr_d !== NOP || imem_req !== 1'b1)
        begin failures++; $display("FAIL wait_bubble%0d got=%h/%b/%h/%b exp=8/0/%h/1", i, pc_f, valid_d, instr_d, imem_req, NOP); end
    end
    step(0, 0, 0, 32'd0, 1);
    checks++; if (instr_d !== mem_word(32'd8) || pc_d !== 32'd8 || valid_d !== 1'b1 || pc_f !== 32'd12)
      begin failures++; $display("FAIL wait_load got=%h/%h/%b/%h exp=%h/8/1/c", instr_d, pc_d, valid_d, pc_f, mem_word(32'd8)); end
  endtask

  task automatic test_stall_skid();
    step(1, 0, 0, 32'd0, 1);
    checks++; if (imem_req !== 1'b0 || pc_f !== 32'd12 || pc_d !== 32'd8 || instr_d !== mem_word(32'd8))
      begin failures++; $display("FAIL hold_enter got=%b/%h/%h/%h exp=0/c/8/%h", imem_req, pc_f, pc_d, instr_d, mem_word(32'd8)); end
    step(1, 0, 0, 32'd0, 1);
    checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL hold_stay got=%h exp=%h", dut_vec, exp_vec()); end
    step(0, 0, 0, 32'd0, 0);
    checks++; if (instr_d !== mem_word(32'd12) || pc_d !== 32'd12 || valid_d !== 1'b1 || pc_f !== 32'd16 || imem_req !== 1'b1)
      begin failures++; $display("FAIL skid_release got=%h/%h/%b/%h exp=%h/c/1/10", instr_d, pc_d, valid_d, pc_f, mem_word(32'd12)); end
    step(0, 0, 0, 32'd0, 1);
    checks++; if (pc_f !== 32'd20) begin failures++; $display("FAIL after_skid_pc got=%h exp=14", pc_f); end
  endtask

  task automatic test_flush();
    step(0, 1, 0, 32'd0, 1);
    checks++; if (valid_d !== 1'b0 || instr_d !== NOP || pc_f !== 32'd20 || imem_req !== 1'b1)
      begin failures++; $display("FAIL flush_bubble got=%b/%h/%h/%b exp=0/%h/14/1", valid_d, instr_d, pc_f, imem_req, NOP); end
    step(0, 0, 0, 32'd0, 1);
    checks++; if (instr_d !== mem_word(32'd20) || pc_d !== 32'd20 || valid_d !== 1'b1)
      begin failures++; $display("FAIL flush_refetch got=%h/%h/%b exp=%h/14/1", instr_d, pc_d, valid_d, mem_word(32'd20)); end
    step(1, 0, 0, 32'd0, 1);
    step(1, 1, 0, 32'd0, 0);
    checks++; if (imem_req !== 1'b1 || pc_f !== 32'd24 || valid_d !== 1'b0)
      begin failures++; $display("FAIL flush_hold got=%b/%h/%b exp=1/18/0", imem_req, pc_f, valid_d); end
    step(0, 0, 0, 32'd0, 1);
    checks++; if (instr_d !== mem_word(32'd24) || pc_d !== 32'd24) begin failures++; $display("FAIL flush_hold_refetch got=%h/%h exp=%h/18", instr_d, pc_d, mem_word(32'd24)); end
  endtask

  task automatic test_redirect();
    step(1, 0, 1, 32'h0000_0103, 1);
    checks++; if (pc_f !== 32'h100 || valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      begin failures++; $display("FAIL redirect got=%h/%b/%b/%h exp=100/0/1/100", pc_f, valid_d, imem_req, imem_addr); end
    step(0, 0, 0, 32'd0, 1);
    checks++; if (instr_d !== mem_word(32'h100) || pc_d !== 32'h100 || valid_d !== 1'b1)
      begin failures++; $display("FAIL redirect_fetch got=%h/%h/%b exp=%h/100/1", instr_d, pc_d, valid_d, mem_word(32'h100)); end
    step(1, 0, 0, 32'd0, 1);
    step(1, 0, 1, 32'h0000_0200, 0);
    checks++; if (pc_f !== 32'h200 || imem_req !== 1'b1 || dut_vec !== exp_vec())
      begin failures++; $display("FAIL redirect_hold got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 32'd0, 1);
    checks++; if (pc_plus4_d !== 32'd0 || pc_d !== 32'hFFFF_FFFC || pc_f !== 32'd0 || valid_d !== 1'b1)
      begin failures++; $display("FAIL wrap got=%h/%h/%h/%b exp=0/fffffffc/0/1", pc_plus4_d, pc_d, pc_f, valid_d); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 32'd0, 1);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pc_f !== 32'd0 || valid_d !== 1'b0 || instr_d !== NOP || imem_req !== 1'b0)
      begin failures++; $display("FAIL async_reset got=%h/%b/%h/%b exp=0/0/%h/0", pc_f, valid_d, instr_d, imem_req, NOP); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 0, 0, 32'd0, 1);
    checks++; if (valid_d !== 1'b0 || dut_vec !== exp_vec()) begin failures++; $display("FAIL post_reset_boot got=%h exp=%h", dut_vec, exp_vec()); end
    step(0, 0, 0, 32'd0, 1);
    checks++; if (instr_d !== 32'h00A0_0093 || valid_d !== 1'b1) begin failures++; $display("FAIL post_reset_fetch got=%h/%b exp=00a00093/1", instr_d, valid_d); end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    int errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, tgt, $urandom_range(0, 3) != 0);
      checks++;
      if (dut_vec !== exp_vec() || imem_addr !== pc_f) begin
        failures++; errs++;
        if (errs <= 10) $display("FAIL random_cycle%0d got=%h addr=%h exp=%h", i, dut_vec, imem_addr, exp_vec());
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (fetch_count !== m_fetch || stall_count !== m_stall) begin
        failures++; errs++;
        if (errs <= 10) $display("FAIL random_counters%0d got=%0d/%0d exp=%0d/%0d", i, fetch_count, stall_count, m_fetch, m_stall);
      end
`endif
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_counters();
    checks++; if (fetch_count !== m_fetch) begin failures++; $display("FAIL fetch_count got=%0d exp=%0d", fetch_count, m_fetch); end
    checks++; if (stall_count !== m_stall) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", stall_count, m_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_boot_stream();
    test_mem_wait();
    test_stall_skid();
    test_flush();
    test_redirect();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_counters();
`endif
    test_reset_mid();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
